// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM address/data on one side, issued instruction to decode on the other.
// The fetch unit uses the master modport; the ROM/decode environment uses slave.
interface fetch_unit_if;
  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 9;

  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_in;
  logic               stall;
  logic               branch_en;
  logic [PC_W-1:0]    branch_target;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    instr_pc;
  logic               valid;

  modport master (
    output pc_out, instr_out, instr_pc, valid,
    input  instr_in, stall, branch_en, branch_target
  );

  modport slave (
    input  pc_out, instr_out, instr_pc, valid,
    output instr_in, stall, branch_en, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and fetch stage in front of a combinational instruction ROM.
// Optional FETCH_CYCLE_COUNT_EN adds a saturating count of cycles spent in RUN.
module fetch_unit #(
  parameter logic [15:0] START_PC   = 16'd0,
  parameter int unsigned ROM_DEPTH  = 55,
  parameter logic [8:0]  HALT_INSTR = 9'h1FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  fetch_unit_if.master       bus,
  output logic               halted,
  output logic               fault
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]        cycle_count
`endif
);
  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;
  logic               out_of_range;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0]        cnt_q, cnt_d;
`endif

  assign out_of_range = 32'(pc_q) >= 32'(ROM_DEPTH);

  // Next-state and next-register values; branch beats stall beats fault beats halt.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    fault_d  = fault_q;
`ifdef FETCH_CYCLE_COUNT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
`ifdef FETCH_CYCLE_COUNT_EN
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
        if (bus.branch_en) begin
          pc_d    = bus.branch_target;
          valid_d = 1'b0;
        end else if (bus.stall) begin
          // hold everything
        end else if (out_of_range) begin
          valid_d  = 1'b0;
          fault_d  = 1'b1;
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (bus.instr_in == HALT_INSTR) begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          ir_d    = bus.instr_in;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 16'd1;
        end
      end
      ST_HALT: begin
        if (start) begin
          halted_d = 1'b0;
          fault_d  = 1'b0;
          pc_d     = START_PC;
          state_d  = ST_RUN;
`ifdef FETCH_CYCLE_COUNT_EN
          cnt_d    = 16'd0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= START_PC;
      ir_q     <= 9'd0;
      ipc_q    <= 16'd0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
      cnt_q    <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
`ifdef FETCH_CYCLE_COUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // pc_out feeds the ROM straight from its flop
  assign bus.pc_out    = pc_q;
  assign bus.instr_out = ir_q;
  assign bus.instr_pc  = ipc_q;
  assign bus.valid     = valid_q;
  assign halted        = halted_q;
  assign fault         = fault_q;
`ifdef FETCH_CYCLE_COUNT_EN
  assign cycle_count   = cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random stall/branch/start/reset traffic,
// all compared each cycle against a behavioural fetch model driven by a bench-owned ROM image.
module tb_fetch_unit;
  localparam logic [15:0] START_PC  = 16'd0;
  localparam int unsigned ROM_DEPTH = 55;
  localparam logic [8:0]  HALT_W    = 9'h1FF;
  localparam int          MODE_IDLE = 0;
  localparam int          MODE_RUN  = 1;
  localparam int          MODE_STOP = 2;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic halted;
  logic fault;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  logic [8:0] rom [0:65535];

  fetch_unit_if bus ();

  fetch_unit #(
    .START_PC  (START_PC),
    .ROM_DEPTH (ROM_DEPTH),
    .HALT_INSTR(HALT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .halted(halted),
    .fault (fault)
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  always_comb bus.instr_in = rom[bus.pc_out];

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int          m_mode;
  logic [15:0] m_pc;
  logic [8:0]  m_ir;
  logic [15:0] m_ipc;
  logic        m_valid;
  logic        m_halted;
  logic        m_fault;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = MODE_IDLE; m_pc = START_PC; m_ir = 9'd0; m_ipc = 16'd0;
    m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_cnt = 16'd0;
  endtask

  // Advance the model by one clock using the ROM word at the model's own pc, then compare.
  task automatic step();
    logic [8:0] w;
    w = rom[m_pc];
    if (reset) begin
      model_reset();
    end else if (m_mode == MODE_IDLE) begin
      if (start) m_mode = MODE_RUN;
    end else if (m_mode == MODE_STOP) begin
      if (start) begin
        m_mode = MODE_RUN; m_pc = START_PC; m_halted = 1'b0; m_fault = 1'b0; m_cnt = 16'd0;
      end
    end else begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (bus.branch_en) begin
        m_pc = bus.branch_target; m_valid = 1'b0;
      end else if (bus.stall) begin
      end else if (32'(m_pc) >= ROM_DEPTH) begin
        m_valid = 1'b0; m_fault = 1'b1; m_halted = 1'b1; m_mode = MODE_STOP;
      end else if (w == HALT_W) begin
        m_valid = 1'b0; m_halted = 1'b1; m_mode = MODE_STOP;
      end else begin
        m_ir = w; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    check("pc_out",    32'(bus.pc_out),    32'(m_pc));
    check("valid",     32'(bus.valid),     32'(m_valid));
    check("instr_out", 32'(bus.instr_out), 32'(m_ir));
    check("instr_pc",  32'(bus.instr_pc),  32'(m_ipc));
    check("halted",    32'(halted),        32'(m_halted));
    check("fault",     32'(fault),         32'(m_fault));
`ifdef FETCH_CYCLE_COUNT_EN
    check("cycle_count", 32'(cycle_count), 32'(m_cnt));
`endif
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 9'($urandom_range(0, 510));
    model_reset();
    reset = 1'b1; start = 1'b0;
    bus.stall = 1'b0; bus.branch_en = 1'b0; bus.branch_target = 16'd0;

    // Reset and start
    step(); step();
    check("rst_pc", 32'(bus.pc_out), 32'(START_PC));
    check("rst_valid", 32'(bus.valid), 32'd0);
    reset = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    check("start_no_valid", 32'(bus.valid), 32'd0);
    step();
    check("first_valid", 32'(bus.valid), 32'd1);
    check("first_ir", 32'(bus.instr_out), 32'(rom[0]));
    check("first_ipc", 32'(bus.instr_pc), 32'd0);
    step();
    check("second_ir", 32'(bus.instr_out), 32'(rom[1]));
    step();
    check("third_ir", 32'(bus.instr_out), 32'(rom[2]));

    // Stall for three cycles while instr_pc=5
    for (int k = 0; k < 20 && m_ipc != 16'd5; k++) step();
    check("reach_ipc5", 32'(m_ipc), 32'd5);
    bus.stall = 1'b1;
    repeat (3) begin
      step();
      check("stall_pc", 32'(bus.pc_out), 32'd6);
      check("stall_ir", 32'(bus.instr_out), 32'(rom[5]));
      check("stall_valid", 32'(bus.valid), 32'd1);
    end
    bus.stall = 1'b0;
    step();
    check("post_stall_ir", 32'(bus.instr_out), 32'(rom[6]));

    // Branch with simultaneous stall
    for (int k = 0; k < 20 && m_pc != 16'd9; k++) step();
    check("reach_pc9", 32'(bus.pc_out), 32'd9);
    bus.branch_en = 1'b1; bus.stall = 1'b1; bus.branch_target = 16'd20;
    step();
    bus.branch_en = 1'b0; bus.stall = 1'b0;
    check("br_pc", 32'(bus.pc_out), 32'd20);
    check("br_valid", 32'(bus.valid), 32'd0);
    step();
    check("br_ir", 32'(bus.instr_out), 32'(rom[20]));
    check("br_ipc", 32'(bus.instr_pc), 32'd20);

    // Halt at pc 12 and restart
    rom[12] = HALT_W;
    bus.branch_en = 1'b1; bus.branch_target = 16'd10;
    step();
    bus.branch_en = 1'b0;
    for (int k = 0; k < 10 && !m_halted; k++) step();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_fault", 32'(fault), 32'd0);
    check("halt_valid", 32'(bus.valid), 32'd0);
    check("halt_pc", 32'(bus.pc_out), 32'd12);
    bus.stall = 1'b1; bus.branch_en = 1'b1; bus.branch_target = 16'd3;
    step(); step();
    bus.stall = 1'b0; bus.branch_en = 1'b0;
    check("halt_frozen", 32'(bus.pc_out), 32'd12);
    start = 1'b1; step(); start = 1'b0;
    check("restart_pc", 32'(bus.pc_out), 32'(START_PC));
    check("restart_halted", 32'(halted), 32'd0);
    step();
    check("restart_ir", 32'(bus.instr_out), 32'(rom[0]));

    // Out of range after the last implemented word
    bus.branch_en = 1'b1; bus.branch_target = 16'd54;
    step();
    bus.branch_en = 1'b0;
    step();
    check("last_valid", 32'(bus.valid), 32'd1);
    check("last_ipc", 32'(bus.instr_pc), 32'd54);
    step();
    check("oor_fault", 32'(fault), 32'd1);
    check("oor_halted", 32'(halted), 32'd1);
    check("oor_valid", 32'(bus.valid), 32'd0);
    check("oor_pc", 32'(bus.pc_out), 32'd55);

    // Counter over 10 RUN cycles including 2 stalls
    reset = 1'b1; step(); reset = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.stall = (k == 3 || k == 4);
      step();
    end
    bus.stall = 1'b0;
`ifdef FETCH_CYCLE_COUNT_EN
    check("cnt_ten", 32'(cycle_count), 32'd10);
`endif
    check("cnt_ipc", 32'(bus.instr_pc), 32'd7);

    // Reset mid-run at pc 30
    rom[12] = 9'($urandom_range(0, 510));
    bus.branch_en = 1'b1; bus.branch_target = 16'd25;
    step();
    bus.branch_en = 1'b0;
    for (int k = 0; k < 10 && m_pc != 16'd30; k++) step();
    check("reach_pc30", 32'(bus.pc_out), 32'd30);
    reset = 1'b1; start = 1'b1; bus.branch_en = 1'b1; bus.branch_target = 16'd40;
    step();
    reset = 1'b0; start = 1'b0; bus.branch_en = 1'b0;
    check("midrst_pc", 32'(bus.pc_out), 32'(START_PC));
    check("midrst_ir", 32'(bus.instr_out), 32'd0);
    check("midrst_ipc", 32'(bus.instr_pc), 32'd0);
    check("midrst_valid", 32'(bus.valid), 32'd0);
    step();
    check("idle_hold_pc", 32'(bus.pc_out), 32'(START_PC));

    // Random traffic with sparse halt words
    for (int i = 0; i < 80; i++)
      rom[i] = ($urandom_range(0, 39) == 0) ? HALT_W : 9'($urandom_range(0, 510));
    for (int k = 0; k < 600; k++) begin
      reset             = ($urandom_range(0, 149) == 0);
      start             = ($urandom_range(0, 7) == 0);
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.branch_en     = ($urandom_range(0, 9) == 0);
      bus.branch_target = 16'($urandom_range(0, 70));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
